// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences FETCH..WRITEBACK, decodes op/funct and
// drives the datapath enables, with MEM_LAT-cycle memory states.
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input logic                   clk,
  input logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  localparam int unsigned    CW   = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0]  LAST = CW'(MEM_LAT - 1);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [3:0]    state, state_nx;
  logic [CW-1:0] wcnt, wcnt_nx;
  logic [5:0]    op_q, op_q_nx;
  logic [2:0]    alu_q, alu_q_nx;
  logic          last;

  logic       pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg;
  logic       regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  // State, wait counter and the decode-time registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      wcnt  <= '0;
      op_q  <= '0;
      alu_q <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      op_q  <= op_q_nx;
      alu_q <= alu_q_nx;
    end
  end

  assign last = (wcnt == LAST);

  // Next state and state-decoded controls; wcnt_nx defaults to 0 so any move clears it
  always_comb begin
    state_nx   = state;
    wcnt_nx    = '0;
    op_q_nx    = op_q;
    alu_q_nx   = alu_q;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    illegal    = 1'b0;
    alusrcb    = 2'd0;
    pcsrc      = 2'd0;
    alucontrol = 3'd0;

    case (state)
      FETCH: begin
        alusrcb = 2'd1;
        if (last) begin
          irwrite  = 1'b1;
          pcwrite  = 1'b1;
          state_nx = DECODE;
        end else begin
          wcnt_nx = wcnt + CW'(1);
        end
      end
      DECODE: begin
        alusrcb = 2'd3;
        op_q_nx = bus.op;
        case (bus.op)
          OP_LW, OP_SW: state_nx = MEMADR;
          OP_RTYPE:     state_nx = RTYPEEX;
          OP_BEQ:       state_nx = BEQEX;
          OP_ADDI:      state_nx = ADDIEX;
          OP_J:         state_nx = JEX;
          default: begin
            illegal  = 1'b1;
            state_nx = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca  = 1'b1;
        alusrcb  = 2'd2;
        state_nx = (op_q == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        if (last) state_nx = MEMWB;
        else      wcnt_nx  = wcnt + CW'(1);
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_nx = FETCH;
      end
      MEMWR: begin
        iord = 1'b1;
        if (last) begin
          memwrite = 1'b1;
          state_nx = FETCH;
        end else begin
          wcnt_nx = wcnt + CW'(1);
        end
      end
      RTYPEEX: begin
        alusrca  = 1'b1;
        state_nx = RTYPEWB;
        case (bus.funct)
          6'h20:   alucontrol = 3'd0;
          6'h22:   alucontrol = 3'd1;
          6'h24:   alucontrol = 3'd2;
          6'h25:   alucontrol = 3'd3;
          6'h2A:   alucontrol = 3'd4;
          default: begin
            illegal  = 1'b1;
            state_nx = FETCH;
          end
        endcase
        alu_q_nx = alucontrol;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        alucontrol = alu_q;
        state_nx   = FETCH;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'd1;
        pcsrc      = 2'd1;
        branch     = 1'b1;
        state_nx   = FETCH;
      end
      ADDIEX: begin
        alusrca  = 1'b1;
        alusrcb  = 2'd2;
        state_nx = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        state_nx = FETCH;
      end
      JEX: begin
        pcsrc    = 2'd2;
        pcwrite  = 1'b1;
        state_nx = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end

  // Reset forces every control low immediately, not just at the next edge
  assign bus.pcen       = reset ? 1'b0 : (pcwrite | (branch & bus.zero));
  assign bus.iord       = reset ? 1'b0 : iord;
  assign bus.memwrite   = reset ? 1'b0 : memwrite;
  assign bus.irwrite    = reset ? 1'b0 : irwrite;
  assign bus.regdst     = reset ? 1'b0 : regdst;
  assign bus.memtoreg   = reset ? 1'b0 : memtoreg;
  assign bus.regwrite   = reset ? 1'b0 : regwrite;
  assign bus.alusrca    = reset ? 1'b0 : alusrca;
  assign bus.alusrcb    = reset ? 2'd0 : alusrcb;
  assign bus.pcsrc      = reset ? 2'd0 : pcsrc;
  assign bus.alucontrol = reset ? 3'd0 : alucontrol;
  assign bus.illegal    = reset ? 1'b0 : illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl at MEM_LAT = 1, 2 and 3.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } outs_t;

  typedef struct {
    int         sel;
    bit         rst;
    logic [5:0] op;
    logic [5:0] funct;
    bit         zero;
    outs_t      exp;
    string      name;
  } vec_t;

  logic       clk;
  logic       rst_v   [3];
  logic [5:0] op_v    [3];
  logic [5:0] funct_v [3];
  logic       zero_v  [3];
  outs_t      outs    [3];

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  // Instance g runs with MEM_LAT = g+1
  for (genvar g = 0; g < 3; g++) begin : gi
    mips_multicycle_ctrl_if ifc ();
    assign ifc.op    = op_v[g];
    assign ifc.funct = funct_v[g];
    assign ifc.zero  = zero_v[g];
    assign outs[g] = {ifc.pcen, ifc.iord, ifc.memwrite, ifc.irwrite, ifc.regdst,
                      ifc.memtoreg, ifc.regwrite, ifc.alusrca, ifc.alusrcb,
                      ifc.pcsrc, ifc.alucontrol, ifc.illegal};
    mips_multicycle_ctrl #(.MEM_LAT(g + 1)) dut (
      .clk   (clk),
      .reset (rst_v[g]),
      .bus   (ifc)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t o_none();
    outs_t o = '0;
    return o;
  endfunction
  function automatic outs_t o_fetch(bit last);
    outs_t o = '0;
    o.alusrcb = 2'd1; o.irwrite = last; o.pcen = last;
    return o;
  endfunction
  function automatic outs_t o_decode(bit ill);
    outs_t o = '0;
    o.alusrcb = 2'd3; o.illegal = ill;
    return o;
  endfunction
  function automatic outs_t o_memadr();
    outs_t o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'd2;
    return o;
  endfunction
  function automatic outs_t o_memrd();
    outs_t o = '0;
    o.iord = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_memwb();
    outs_t o = '0;
    o.memtoreg = 1'b1; o.regwrite = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_memwr(bit last);
    outs_t o = '0;
    o.iord = 1'b1; o.memwrite = last;
    return o;
  endfunction
  function automatic outs_t o_rtex(logic [2:0] alu, bit ill);
    outs_t o = '0;
    o.alusrca = 1'b1; o.alucontrol = alu; o.illegal = ill;
    return o;
  endfunction
  function automatic outs_t o_rtwb(logic [2:0] alu);
    outs_t o = '0;
    o.regdst = 1'b1; o.regwrite = 1'b1; o.alucontrol = alu;
    return o;
  endfunction
  function automatic outs_t o_beq(bit z);
    outs_t o = '0;
    o.alusrca = 1'b1; o.alucontrol = 3'd1; o.pcsrc = 2'd1; o.pcen = z;
    return o;
  endfunction
  function automatic outs_t o_addiex();
    outs_t o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'd2;
    return o;
  endfunction
  function automatic outs_t o_addiwb();
    outs_t o = '0;
    o.regwrite = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_jex();
    outs_t o = '0;
    o.pcsrc = 2'd2; o.pcen = 1'b1;
    return o;
  endfunction

  function automatic void add(int sel, bit r, logic [5:0] op, logic [5:0] funct,
                              bit z, outs_t e, string n);
    vec_t v;
    v.sel = sel; v.rst = r; v.op = op; v.funct = funct; v.zero = z;
    v.exp = e; v.name = n;
    vecs.push_back(v);
  endfunction

  // Fetch cycles for an instance with latency lat; fetch strobes only on the last one
  function automatic void add_fetch(int sel, int lat, logic [5:0] op, logic [5:0] funct);
    for (int k = 0; k < lat; k++)
      add(sel, 1'b0, op, funct, 1'b0, o_fetch(k == lat - 1), $sformatf("fetch%0d", k));
  endfunction

  // Drive one cycle at the falling edge; unselected instances sit in reset
  task automatic step(int sel, bit r, logic [5:0] op, logic [5:0] funct, bit z,
                      outs_t e, string n);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_v[i] = (i != sel) || r;
    op_v[sel]    = op;
    funct_v[sel] = funct;
    zero_v[sel]  = z;
    #1;
    checks++;
    if (outs[sel] !== e) begin
      errors++;
      $display("FAIL %s (lat%0d): got %h required %h", n, sel + 1, outs[sel], e);
    end
  endtask

  logic [5:0] fn_tab  [4];
  logic [2:0] alu_tab [4];

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1; op_v[i] = 6'h00; funct_v[i] = 6'h20; zero_v[i] = 1'b0;
    end
    fn_tab  = '{6'h22, 6'h24, 6'h25, 6'h2A};
    alu_tab = '{3'd1, 3'd2, 3'd3, 3'd4};

    // MEM_LAT = 1
    for (int k = 0; k < 3; k++) add(0, 1'b1, 6'h00, 6'h20, 1'b0, o_none(), "reset");
    add_fetch(0, 1, 6'h00, 6'h20);
    add(0, 0, 6'h00, 6'h20, 0, o_decode(0),    "add_decode");
    add(0, 0, 6'h00, 6'h20, 0, o_rtex(0, 0),   "add_ex");
    add(0, 0, 6'h00, 6'h20, 0, o_rtwb(0),      "add_wb");
    for (int k = 0; k < 4; k++) begin
      add_fetch(0, 1, 6'h00, fn_tab[k]);
      add(0, 0, 6'h00, fn_tab[k], 0, o_decode(0),           "r_decode");
      add(0, 0, 6'h00, fn_tab[k], 0, o_rtex(alu_tab[k], 0), "r_ex");
      add(0, 0, 6'h00, fn_tab[k], 0, o_rtwb(alu_tab[k]),    "r_wb");
    end
    add_fetch(0, 1, 6'h00, 6'h27);
    add(0, 0, 6'h00, 6'h27, 0, o_decode(0),    "badfn_decode");
    add(0, 0, 6'h00, 6'h27, 0, o_rtex(0, 1),   "badfn_ex");
    add_fetch(0, 1, 6'h04, 6'h00);
    add(0, 0, 6'h04, 6'h00, 1, o_decode(0),    "beq1_decode");
    add(0, 0, 6'h04, 6'h00, 1, o_beq(1),       "beq_taken");
    add_fetch(0, 1, 6'h04, 6'h00);
    add(0, 0, 6'h04, 6'h00, 0, o_decode(0),    "beq0_decode");
    add(0, 0, 6'h04, 6'h00, 0, o_beq(0),       "beq_not_taken");
    add_fetch(0, 1, 6'h08, 6'h00);
    add(0, 0, 6'h08, 6'h00, 0, o_decode(0),    "addi_decode");
    add(0, 0, 6'h08, 6'h00, 0, o_addiex(),     "addi_ex");
    add(0, 0, 6'h08, 6'h00, 0, o_addiwb(),     "addi_wb");
    add_fetch(0, 1, 6'h02, 6'h00);
    add(0, 0, 6'h02, 6'h00, 0, o_decode(0),    "j_decode");
    add(0, 0, 6'h02, 6'h00, 0, o_jex(),        "j_ex");
    add_fetch(0, 1, 6'h3F, 6'h00);
    add(0, 0, 6'h3F, 6'h00, 0, o_decode(1),    "badop_decode");
    add_fetch(0, 1, 6'h00, 6'h20);

    // MEM_LAT = 2: sw, then an unsupported op
    add_fetch(1, 2, 6'h2B, 6'h00);
    add(1, 0, 6'h2B, 6'h00, 0, o_decode(0),    "sw_decode");
    add(1, 0, 6'h2B, 6'h00, 0, o_memadr(),     "sw_memadr");
    add(1, 0, 6'h2B, 6'h00, 0, o_memwr(0),     "sw_memwr0");
    add(1, 0, 6'h2B, 6'h00, 0, o_memwr(1),     "sw_memwr1");
    add_fetch(1, 2, 6'h3F, 6'h00);
    add(1, 0, 6'h3F, 6'h00, 0, o_decode(1),    "badop2_decode");
    add(1, 0, 6'h3F, 6'h00, 0, o_fetch(0),     "badop2_return");

    // MEM_LAT = 3: lw; live op changes to sw after DECODE, latched op must win
    add_fetch(2, 3, 6'h23, 6'h00);
    add(2, 0, 6'h23, 6'h00, 0, o_decode(0),    "lw_decode");
    add(2, 0, 6'h2B, 6'h00, 0, o_memadr(),     "lw_memadr");
    for (int k = 0; k < 3; k++)
      add(2, 0, 6'h2B, 6'h00, 0, o_memrd(), $sformatf("lw_memrd%0d", k));
    add(2, 0, 6'h2B, 6'h00, 0, o_memwb(),      "lw_memwb");
    add(2, 0, 6'h2B, 6'h00, 0, o_fetch(0),     "lw_next_fetch");

    foreach (vecs[i])
      step(vecs[i].sel, vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].zero,
           vecs[i].exp, vecs[i].name);

    // Reset in the middle of MEMRD aborts the lw with no register write
    step(2, 1, 6'h23, 6'h00, 0, o_none(),   "abort_pre_reset");
    step(2, 0, 6'h23, 6'h00, 0, o_fetch(0), "abort_fetch0");
    step(2, 0, 6'h23, 6'h00, 0, o_fetch(0), "abort_fetch1");
    step(2, 0, 6'h23, 6'h00, 0, o_fetch(1), "abort_fetch2");
    step(2, 0, 6'h23, 6'h00, 0, o_decode(0), "abort_decode");
    step(2, 0, 6'h23, 6'h00, 0, o_memadr(),  "abort_memadr");
    step(2, 0, 6'h23, 6'h00, 0, o_memrd(),   "abort_memrd0");
    step(2, 0, 6'h23, 6'h00, 0, o_memrd(),   "abort_memrd1");
    step(2, 1, 6'h00, 6'h20, 0, o_none(),    "abort_async_reset");
    step(2, 1, 6'h00, 6'h20, 0, o_none(),    "abort_reset_held");
    step(2, 0, 6'h00, 6'h20, 0, o_fetch(0),  "abort_refetch0");
    step(2, 0, 6'h00, 6'h20, 0, o_fetch(0),  "abort_refetch1");
    step(2, 0, 6'h00, 6'h20, 0, o_fetch(1),  "abort_refetch2");
    step(2, 0, 6'h00, 6'h20, 0, o_decode(0), "abort_after_decode");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
